// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus.
// master = fetch side (drives requests), slave = memory side.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: issues word fetches, pairs in-order responses with
// their addresses and buffers {pc, inst} in a 2-entry FIFO.
// Ports: clk, rst (async, active-high); imem (master bus);
// redirect/redirect_pc (control-flow change); stall (decode hold);
// inst_encoding/pc/inst_valid (FIFO head toward decode).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  fetch_unit_if.master      imem,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              stall,
  output logic [31:0]       inst_encoding,
  output logic [31:0]       pc,
  output logic              inst_valid
);

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [31:0] r_fetch_pc;
  logic [1:0]  r_outstanding;
  logic [1:0]  r_drop_cnt;
  logic [0:0]  r_state;
  logic [31:0] r_aq [2];
  logic [31:0] r_fpc [2];
  logic [31:0] r_finst [2];
  logic        r_head;
  logic [1:0]  r_fifo_cnt;

  logic [2:0]  w_occ;
  logic        w_req_valid;
  logic        w_accept;
  logic        w_resp;
  logic        w_drain;
  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_out_left;
  logic        w_aq_idx;
  logic        w_wr_idx;
  logic [0:0]  w_state_nxt;
  logic [1:0]  w_drop_nxt;

  // Slots in flight: in-memory requests plus buffered
  // instructions. Capping at 2 makes FIFO overflow impossible.
  assign w_occ = {1'b0, r_outstanding}
               + {1'b0, r_fifo_cnt};

  assign w_req_valid = !rst && !redirect
                     && (w_occ < 3'd2);
  assign w_accept = w_req_valid && imem.imem_req_ready;
  assign w_resp   = imem.imem_resp_valid;
  assign w_drain  = (r_state == S_DRAIN);

  // Responses are dropped while draining stale requests and on
  // the redirect cycle itself.
  assign w_push = w_resp && !redirect && !w_drain;
  assign w_pop  = inst_valid && !stall && !redirect;

  assign w_out_left = r_outstanding - {1'b0, w_resp};

  // Address queue slot for a new request after the head shifts
  // out; accept needs outstanding <= 1 so slot 0 or 1.
  assign w_aq_idx = w_out_left[0];
  assign w_wr_idx = r_head + r_fifo_cnt[0];

  assign imem.imem_req_valid = w_req_valid;
  assign imem.imem_req_addr  = r_fetch_pc;

  assign inst_valid    = (r_fifo_cnt != 2'd0);
  assign inst_encoding = inst_valid ? r_finst[r_head]
                                    : 32'h0;
  assign pc            = inst_valid ? r_fpc[r_head]
                                    : r_fetch_pc;

  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop_cnt;
    unique case (1'b1)
      redirect: begin
        // Everything still in memory is stale, except a response
        // that lands now, which is discarded on the spot.
        w_drop_nxt  = w_out_left;
        w_state_nxt = (w_out_left != 2'd0) ? S_DRAIN
                                           : S_FETCH;
      end
      (w_drain && w_resp && !redirect): begin
        w_drop_nxt = r_drop_cnt - 2'd1;
        if (r_drop_cnt == 2'd1)
          w_state_nxt = S_FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= 2'd0;
      r_drop_cnt    <= 2'd0;
      r_state       <= S_FETCH;
      r_aq[0]       <= 32'h0;
      r_aq[1]       <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_drop_cnt <= w_drop_nxt;
      r_outstanding <= r_outstanding
                     + {1'b0, w_accept}
                     - {1'b0, w_resp};
      if (w_resp)
        r_aq[0] <= r_aq[1];
      if (w_accept)
        r_aq[w_aq_idx] <= r_fetch_pc;
      if (redirect)
        r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      else if (w_accept)
        r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= 1'b0;
      r_fifo_cnt <= 2'd0;
      r_fpc[0]   <= 32'h0;
      r_fpc[1]   <= 32'h0;
      r_finst[0] <= 32'h0;
      r_finst[1] <= 32'h0;
    end else if (redirect) begin
      r_head     <= 1'b0;
      r_fifo_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_fpc[w_wr_idx]   <= r_aq[0];
        r_finst[w_wr_idx] <= imem.imem_resp_data;
      end
      if (w_pop)
        r_head <= ~r_head;
      r_fifo_cnt <= r_fifo_cnt
                  + {1'b0, w_push}
                  - {1'b0, w_pop};
    end
  end

  a_no_orphan_resp: assert property (
    @(posedge clk) disable iff (rst)
    imem.imem_resp_valid |-> (r_outstanding != 2'd0));

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    w_push |-> (r_fifo_cnt != 2'd2));

  a_drop_bound: assert property (
    @(posedge clk) disable iff (rst)
    r_drop_cnt <= r_outstanding);

endmodule
